// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory port between the fetch stage and
// the boot/program loader.
//
// The arbiter runs a three-state sequence. BOOT gives the memory to the loader
// only and holds the fetch stage. A single l_done pulse moves to DRAIN, which
// lasts one cycle so that a read still in flight can return. RUN then gives
// fetch priority. A loader that has waited STARVE_MAX consecutive RUN cycles
// gets one forced grant, and fetch is stalled for that cycle.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   f_req_i, f_addr_i       fetch read request and byte address
//   f_gnt_o                 fetch request accepted this cycle
//   f_rvalid_o, f_rdata_o   fetch read response (one cycle after grant)
//   l_req_i, l_we_i         loader request and write enable (0 = read-back)
//   l_addr_i, l_wdata_i     loader byte address and write data
//   l_done_i                loader finished (single-cycle pulse)
//   l_gnt_o                 loader request accepted this cycle
//   l_rvalid_o, l_rdata_o   loader read-back response
//   mem_en_o, mem_we_o      memory strobe and write enable
//   mem_addr_o, mem_wdata_o memory word-aligned address and write data
//   mem_rdata_i             memory read data, one cycle after a read strobe
//   fetch_hold_o            stalls the fetch stage (drives pc_write low)
//   boot_done_o             program image loaded, arbiter in RUN
//   load_count_o            saturating count of accepted loader writes
module imem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             f_req_i,
    input  logic [31:0]      f_addr_i,
    output logic             f_gnt_o,
    output logic             f_rvalid_o,
    output logic [31:0]      f_rdata_o,
    input  logic             l_req_i,
    input  logic             l_we_i,
    input  logic [31:0]      l_addr_i,
    input  logic [31:0]      l_wdata_i,
    input  logic             l_done_i,
    output logic             l_gnt_o,
    output logic             l_rvalid_o,
    output logic [31:0]      l_rdata_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             fetch_hold_o,
    output logic             boot_done_o,
    output logic [CNT_W-1:0] load_count_o
);
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    // Wide enough to hold STARVE_MAX, and at least one bit when STARVE_MAX is 0.
    localparam int               SW         = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    starve_q, starve_d;
    // Owner tag of the read issued last cycle: bit 0 = fetch, bit 1 = loader.
    logic [1:0]       owner_q, owner_d;
    logic [31:0]      f_rdata_q, l_rdata_q;
    logic [CNT_W-1:0] load_count_q, load_count_d;

    logic in_boot, in_run, starved, forced;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{f_addr_i[1:0], l_addr_i[1:0]};

    always_comb begin
        in_boot = state_q == S_BOOT;
        in_run  = state_q == S_RUN;
        starved = starve_q == STARVE_LIM;
        // The reset gate keeps the loader from being granted while reset is held,
        // even though BOOT would otherwise pass l_req straight through.
        l_gnt_o = reset_n & l_req_i & (in_boot | (in_run & (~f_req_i | starved)));
        f_gnt_o = reset_n & in_run & f_req_i & ~l_gnt_o;
        // A loader grant in RUN while fetch is also requesting can only be the
        // starvation override, so fetch stalls for exactly that cycle.
        forced       = in_run & l_gnt_o & f_req_i;
        fetch_hold_o = ~in_run | forced;
        boot_done_o  = in_run;
        mem_en_o     = f_gnt_o | l_gnt_o;
        mem_we_o     = l_gnt_o & l_we_i;
        mem_addr_o   = l_gnt_o ? {l_addr_i[31:2], 2'b00} :
                       f_gnt_o ? {f_addr_i[31:2], 2'b00} : 32'd0;
        mem_wdata_o  = l_wdata_i;
        state_d      = in_boot ? (l_done_i ? S_DRAIN : S_BOOT) : S_RUN;
        starve_d     = (in_run & l_req_i & ~l_gnt_o) ?
                       (starved ? starve_q : starve_q + SW'(1)) : '0;
        owner_d      = {l_gnt_o & ~l_we_i, f_gnt_o};
        load_count_d = (mem_we_o & ~&load_count_q) ? load_count_q + CNT_ONE : load_count_q;
        // Memory data arrives in the same cycle as the registered valid. It is
        // forwarded directly, and the hold register keeps it for later cycles.
        f_rvalid_o   = owner_q[0];
        l_rvalid_o   = owner_q[1];
        f_rdata_o    = owner_q[0] ? mem_rdata_i : f_rdata_q;
        l_rdata_o    = owner_q[1] ? mem_rdata_i : l_rdata_q;
        load_count_o = load_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_BOOT;
            starve_q     <= '0;
            owner_q      <= '0;
            f_rdata_q    <= '0;
            l_rdata_q    <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            owner_q      <= owner_d;
            f_rdata_q    <= f_rdata_o;
            l_rdata_q    <= l_rdata_o;
            load_count_q <= load_count_d;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: random and directed stimulus against a cycle-level reference
// model, with a scoreboard queue checked by an independent read-response monitor.
module tb_imem_arbiter;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W      = 16;

    logic clk = 0, reset_n = 0;
    logic f_req = 0, l_req = 0, l_we = 0, l_done = 0;
    logic [31:0] f_addr = 0, l_addr = 0, l_wdata = 0;
    logic f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we, fetch_hold, boot_done;
    logic [31:0] f_rdata, l_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic [CNT_W-1:0] load_count;

    imem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
        .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_done_i(l_done), .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .fetch_hold_o(fetch_hold), .boot_done_o(boot_done), .load_count_o(load_count)
    );

    always #5 clk = ~clk;

    // Memory the DUT actually talks to; one-cycle read latency.
    logic [31:0] env_mem [64];
    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr[7:2]] <= mem_wdata;
            else mem_rdata <= env_mem[mem_addr[7:2]];
        end

    typedef struct {bit own_l; logic [31:0] data;} exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0;

    // Reference model state.
    int phase = 0;          // 0 boot, 1 drain, 2 run
    int waited = 0;         // consecutive RUN cycles the loader has gone ungranted
    int lcount = 0;
    logic [31:0] ref_mem [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit eg_l, eg_f, forced;
        int nxt;
        if (!reset_n) begin
            phase = 0; waited = 0; lcount = 0; sb.delete();
            chk("rst_l_gnt", l_gnt, 0);
            chk("rst_f_gnt", f_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_boot_done", boot_done, 0);
            chk("rst_fetch_hold", fetch_hold, 1);
            chk("rst_load_count", load_count, 0);
            chk("rst_rvalid", {f_rvalid, l_rvalid}, 0);
            chk("rst_f_rdata", f_rdata, 0);
            chk("rst_l_rdata", l_rdata, 0);
            return;
        end
        eg_l = 0; eg_f = 0; forced = 0; nxt = phase;
        if (phase == 0) begin
            eg_l = l_req;
            if (l_done) nxt = 1;
        end else if (phase == 1) nxt = 2;
        else begin
            eg_l = l_req && (!f_req || waited >= STARVE_MAX);
            eg_f = f_req && !eg_l;
            forced = eg_l && f_req;
        end
        chk("l_gnt", l_gnt, eg_l);
        chk("f_gnt", f_gnt, eg_f);
        chk("mem_en", mem_en, eg_l | eg_f);
        chk("mem_we", mem_we, eg_l & l_we);
        chk("fetch_hold", fetch_hold, (phase != 2) || forced);
        chk("boot_done", boot_done, phase == 2);
        chk("load_count", load_count, lcount);
        if (eg_l) chk("mem_addr_l", mem_addr, l_addr & ~32'd3);
        if (eg_f) chk("mem_addr_f", mem_addr, f_addr & ~32'd3);
        if (eg_l && l_we) chk("mem_wdata", mem_wdata, l_wdata);
        if (eg_l && l_we) begin
            ref_mem[l_addr[7:2]] = l_wdata;
            if (lcount != (1 << CNT_W) - 1) lcount++;
        end
        if (eg_l && !l_we) sb.push_back('{1'b1, ref_mem[l_addr[7:2]]});
        if (eg_f) sb.push_back('{1'b0, ref_mem[f_addr[7:2]]});
        if (phase == 2 && l_req && !eg_l) waited = (waited < STARVE_MAX) ? waited + 1 : STARVE_MAX;
        else waited = 0;
        phase = nxt;
    endtask

    task automatic drive(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                         input logic [31:0] la, input logic [31:0] ld, input bit dn, input bit rn);
        @(negedge clk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
        l_done = dn; reset_n = rn;
        #3;
        model_check();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom, $urandom, $urandom_range(0, 9) == 0, 1);
    endtask

    // Read-response monitor: every response must match the oldest pending read.
    logic [31:0] last_f = 0, last_l = 0;
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!reset_n) begin
            last_f = 0; last_l = 0;
        end else begin
            if (f_rvalid || l_rvalid) begin
                chk("rvalid_exclusive", {31'd0, f_rvalid & l_rvalid}, 0);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: f=%b l=%b with no pending read at %0t", f_rvalid, l_rvalid, $time);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_owner", {f_rvalid, l_rvalid}, e.own_l ? 2'b01 : 2'b10);
                    chk("rdata", e.own_l ? l_rdata : f_rdata, e.data);
                end
            end else if (sb.size() != 0) begin
                checks++; errors++;
                $display("FAIL missing_rvalid: got none, expected response for %s at %0t", sb[0].own_l ? "loader" : "fetch", $time);
                void'(sb.pop_front());
            end
            if (!f_rvalid) chk("f_rdata_hold", f_rdata, last_f);
            if (!l_rvalid) chk("l_rdata_hold", l_rdata, last_l);
            last_f = f_rdata; last_l = l_rdata;
        end
    end

    initial begin
        int first, ngnt, nhold;
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        // Reset held with both requesters active: nothing may be granted.
        drive(1, 32'h40, 1, 1, 32'h80, 32'h1234, 0, 0);
        drive(1, 32'h44, 1, 0, 32'h84, 32'h5678, 0, 0);
        // Boot load with fetch also requesting; l_done rides on the last write.
        drive(1, 32'h100, 1, 1, 32'h0, 32'hA0A0_0000, 0, 1);
        drive(1, 32'h104, 1, 1, 32'h4, 32'hA0A0_0004, 0, 1);
        drive(1, 32'h108, 1, 1, 32'h8, 32'hA0A0_0008, 0, 1);
        drive(1, 32'h10C, 1, 0, 32'h4, 32'h0, 0, 1);
        drive(1, 32'h110, 1, 1, 32'hC, 32'hA0A0_000C, 1, 1);
        // DRAIN: requests present but no grant allowed.
        drive(1, 32'h0, 1, 1, 32'h20, 32'h0, 0, 1);
        chk("boot_load_count", load_count, 4);
        // Fetch read of an unaligned address.
        drive(1, 32'h6, 0, 0, 32'h0, 32'h0, 0, 1);
        chk("fetch_word_addr", mem_addr, 32'h4);
        idle();
        // Starvation: both held; the loader must win exactly once, on cycle 9.
        first = 0; ngnt = 0; nhold = 0;
        for (int i = 1; i <= 12; i++) begin
            drive(1, 32'h8, 1, 0, 32'h10, 32'h0, 0, 1);
            if (l_gnt) begin ngnt++; if (first == 0) first = i; end
            if (fetch_hold) nhold++;
        end
        chk("starve_grant_cycle", first, 9);
        chk("starve_grant_count", ngnt, 1);
        chk("starve_hold_count", nhold, 1);
        idle();
        // Back-to-back fetch read then loader read-back.
        drive(1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 1);
        drive(0, 32'h0, 1, 0, 32'h20, 32'h0, 0, 1);
        idle();
        random_cycles(300);
        // Reset right after a fetch grant, before its response is registered.
        drive(1, 32'h30, 0, 0, 32'h0, 32'h0, 0, 1);
        #1 reset_n = 0;
        sb.delete();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_reset_f_rvalid", f_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("post_reset_fetch_hold", fetch_hold, 1);
        chk("post_reset_boot", boot_done, 0);
        // Read-back issued together with l_done returns during DRAIN.
        drive(0, 0, 1, 1, 32'h14, 32'hBEEF_0014, 0, 1);
        drive(1, 0, 1, 0, 32'h14, 32'h0, 1, 1);
        idle();
        random_cycles(300);
        for (int i = 0; i < 4; i++) idle();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
